// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: registered lookup, in-place/round-robin
// training, per-entry invalidate, and a one-set-per-cycle sweep on reset/flush.
module btb_set_assoc #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [31:2]      lookup_pc,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [31:2]      resp_target,
  output logic [WAY_W-1:0] resp_way,
  input  logic             upd_valid,
  input  logic [31:2]      upd_pc,
  input  logic [31:2]      upd_target,
  input  logic             inv_valid,
  input  logic [31:2]      inv_pc,
  input  logic             flush,
  output logic             busy
);

  typedef enum logic {SWEEP, READY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
  logic [31:2]         tgt_q   [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]    ptr_q   [NUM_SETS];

  logic [IDX_W-1:0] lk_idx, upd_idx, inv_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag, inv_tag;

  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign inv_idx = inv_pc[IDX_W+1:2];
  assign inv_tag = inv_pc[31:IDX_W+2];

  assign busy = (state_q == SWEEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = SWEEP;
      cnt_d   = '0;
    end else if (state_q == SWEEP) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(NUM_SETS - 1)) state_d = READY;
    end
  end

  logic             lk_hit, upd_hit, upd_free, inv_hit;
  logic [WAY_W-1:0] lk_way, upd_hit_way, upd_free_way, inv_way;
  logic [31:2]      lk_tgt;

  always_comb begin
    lk_hit       = 1'b0;
    lk_way       = '0;
    lk_tgt       = '0;
    upd_hit      = 1'b0;
    upd_hit_way  = '0;
    upd_free     = 1'b0;
    upd_free_way = '0;
    inv_hit      = 1'b0;
    inv_way      = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
        lk_tgt = tgt_q[lk_idx][w];
      end
      if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
        upd_hit     = 1'b1;
        upd_hit_way = WAY_W'(w);
      end
      if (!valid_q[upd_idx][w] && !upd_free) begin
        upd_free     = 1'b1;
        upd_free_way = WAY_W'(w);
      end
      if (valid_q[inv_idx][w] && tag_q[inv_idx][w] == inv_tag) begin
        inv_hit = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  logic             ready, upd_en, inv_en, use_ptr;
  logic [WAY_W-1:0] upd_way, ptr_next;

  assign ready    = (state_q == READY) && !rst;
  assign upd_en   = ready && upd_valid && !(inv_valid && inv_pc == upd_pc);
  assign inv_en   = ready && inv_valid && inv_hit;
  assign use_ptr  = !upd_hit && !upd_free;
  assign upd_way  = upd_hit ? upd_hit_way : (upd_free ? upd_free_way : ptr_q[upd_idx]);
  assign ptr_next = (ptr_q[upd_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[upd_idx] + 1'b1;

  // Victim is chosen from pre-write state; the update is applied after the
  // invalidate so a fill into the invalidated way still lands valid.
  always_ff @(posedge clk) begin
    if (state_q == SWEEP) begin
      valid_q[cnt_q] <= '0;
      ptr_q[cnt_q]   <= '0;
    end else begin
      if (inv_en) valid_q[inv_idx][inv_way] <= 1'b0;
      if (upd_en) begin
        valid_q[upd_idx][upd_way] <= 1'b1;
        tag_q[upd_idx][upd_way]   <= upd_tag;
        tgt_q[upd_idx][upd_way]   <= upd_target;
        if (use_ptr) ptr_q[upd_idx] <= ptr_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_target <= '0;
      resp_way    <= '0;
    end else begin
      resp_valid  <= lookup_valid;
      resp_hit    <= lookup_valid && ready && lk_hit;
      resp_target <= (lookup_valid && ready && lk_hit) ? lk_tgt : '0;
      resp_way    <= (lookup_valid && ready && lk_hit) ? lk_way : '0;
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Randomized and directed bench for btb_set_assoc against a PC-level
// reference table that clears whole on reset/flush.
module tb_btb_set_assoc;
  localparam int NS = 64;
  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst, lookup_valid, upd_valid, inv_valid, flush;
  logic [31:2] lookup_pc, upd_pc, upd_target, inv_pc;
  logic        resp_valid, resp_hit, busy;
  logic [31:2] resp_target;
  logic [0:0]  resp_way;

  always #5 clk = ~clk;

  btb_set_assoc #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_target(resp_target),
    .resp_way(resp_way), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .inv_valid(inv_valid), .inv_pc(inv_pc),
    .flush(flush), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference table keyed by full PC; "left" is the number of busy cycles remaining.
  bit          m_v  [NS][NW];
  logic [29:0] m_pc [NS][NW];
  logic [29:0] m_tg [NS][NW];
  int          m_ptr[NS];
  int          left = 0;

  function automatic int set_of(input logic [29:0] pc);
    return int'(pc) % NS;
  endfunction

  function automatic int find(input logic [29:0] pc);
    int s = set_of(pc);
    for (int w = 0; w < NW; w++)
      if (m_v[s][w] && m_pc[s][w] == pc) return w;
    return -1;
  endfunction

  function automatic void clear_all();
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NW; w++) m_v[s][w] = 1'b0;
    end
  endfunction

  function automatic void apply(input bit uv, input logic [29:0] upc, input logic [29:0] utg,
                                input bit iv, input logic [29:0] ipc);
    int us = set_of(upc);
    int uw = -1;
    int iw;
    bit adv = 1'b0;
    bit do_u = uv && !(iv && ipc == upc);
    if (do_u) begin
      uw = find(upc);
      if (uw < 0) begin
        for (int w = NW - 1; w >= 0; w--) if (!m_v[us][w]) uw = w;
        if (uw < 0) begin
          uw  = m_ptr[us];
          adv = 1'b1;
        end
      end
    end
    if (iv) begin
      iw = find(ipc);
      if (iw >= 0) m_v[set_of(ipc)][iw] = 1'b0;
    end
    if (do_u) begin
      m_v[us][uw]  = 1'b1;
      m_pc[us][uw] = upc;
      m_tg[us][uw] = utg;
      if (adv) m_ptr[us] = (m_ptr[us] + 1) % NW;
    end
  endfunction

  task automatic cyc(input bit lv, input logic [29:0] lpc,
                     input bit uv, input logic [29:0] upc, input logic [29:0] utg,
                     input bit iv, input logic [29:0] ipc, input bit fl, input bit r);
    bit          e_v, e_h;
    logic [29:0] e_t;
    int          e_w, f;
    rst = r; lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utg;
    inv_valid = iv; inv_pc = ipc; flush = fl;
    e_v = lv && !r;
    e_h = 1'b0;
    e_t = '0;
    e_w = 0;
    if (e_v && left == 0) begin
      f = find(lpc);
      if (f >= 0) begin
        e_h = 1'b1;
        e_t = m_tg[set_of(lpc)][f];
        e_w = f;
      end
    end
    if (r || fl) begin
      clear_all();
      left = NS;
    end else if (left > 0) begin
      left--;
    end else begin
      apply(uv, upc, utg, iv, ipc);
    end
    @(posedge clk);
    #1;
    check("resp_valid", resp_valid, e_v);
    check("resp_hit", resp_hit, e_h);
    check("resp_target", resp_target, e_t);
    check("resp_way", resp_way, e_w);
    check("busy", busy, left > 0);
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, '0, 0, '0, 0, 0);
  endtask
  task automatic lookup(input logic [29:0] pc);
    cyc(1, pc, 0, '0, '0, 0, '0, 0, 0);
  endtask
  task automatic upd(input logic [29:0] pc, input logic [29:0] tg);
    cyc(0, '0, 1, pc, tg, 0, '0, 0, 0);
  endtask
  task automatic inv(input logic [29:0] pc);
    cyc(0, '0, 0, '0, '0, 1, pc, 0, 0);
  endtask

  function automatic logic [29:0] rnd_pc();
    logic [29:0] t = 30'($urandom_range(0, 3));
    logic [29:0] s = 30'($urandom_range(0, 3));
    return (t << 6) | s;
  endfunction

  initial begin
    int nbusy;
    logic [29:0] a, b;

    cyc(0, '0, 0, '0, '0, 0, '0, 0, 1);
    cyc(0, '0, 0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < NS; i++) lookup(30'h400);
    check("sweep_done_busy", busy, 0);

    upd(30'h400, 30'h800);
    lookup(30'h400);
    check("tp_hit_1000", resp_hit, 1);
    check("tp_tgt_1000", resp_target, 30'h800);
    lookup(30'h401);
    check("tp_miss_1004", resp_hit, 0);

    upd(30'h440, 30'h111);
    upd(30'h480, 30'h222);
    lookup(30'h440);
    check("tp_way_1100", resp_way, 1);
    lookup(30'h480);
    check("tp_way_1200", resp_way, 0);
    check("tp_hit_1200", resp_hit, 1);
    lookup(30'h400);
    check("tp_evict_1000", resp_hit, 0);
    upd(30'h440, 30'h333);
    lookup(30'h440);
    check("tp_retarget", resp_target, 30'h333);

    inv(30'h480);
    lookup(30'h480);
    check("tp_inv_miss", resp_hit, 0);
    upd(30'h4C0, 30'h444);
    lookup(30'h4C0);
    check("tp_fill_lowest", resp_way, 0);
    upd(30'h500, 30'h555);
    lookup(30'h500);
    check("tp_ptr_kept", resp_way, 1);

    cyc(1, 30'h540, 1, 30'h540, 30'h666, 0, '0, 0, 0);
    check("tp_rbw_miss", resp_hit, 0);
    lookup(30'h540);
    check("tp_rbw_hit", resp_hit, 1);
    cyc(0, '0, 1, 30'h540, 30'h777, 1, 30'h540, 0, 0);
    lookup(30'h540);
    check("tp_updinv_miss", resp_hit, 0);

    upd(30'h10, 30'h1); upd(30'h21, 30'h2); upd(30'h32, 30'h3); upd(30'h43, 30'h4);
    lookup(30'h21);
    check("tp_pre_flush_hit", resp_hit, 1);
    nbusy = 0;
    cyc(0, '0, 0, '0, '0, 0, '0, 1, 0);
    nbusy += int'(busy);
    for (int i = 0; i < 9; i++) begin
      upd(30'h10 + 30'(i), 30'h99);
      nbusy += int'(busy);
    end
    cyc(0, '0, 0, '0, '0, 0, '0, 1, 0);
    nbusy += int'(busy);
    for (int i = 0; i < 69; i++) begin
      idle();
      nbusy += int'(busy);
    end
    check("flush_busy_len", nbusy, 74);
    lookup(30'h10); check("post_flush_miss0", resp_hit, 0);
    lookup(30'h21); check("post_flush_miss1", resp_hit, 0);
    lookup(30'h32); check("post_flush_miss2", resp_hit, 0);
    lookup(30'h43); check("post_flush_miss3", resp_hit, 0);

    for (int i = 0; i < 3000; i++) begin
      a = rnd_pc();
      b = ($urandom_range(0, 1) == 0) ? a : rnd_pc();
      cyc(1'($urandom_range(0, 1)), rnd_pc(),
          $urandom_range(0, 2) == 0, a, 30'($urandom),
          $urandom_range(0, 5) == 0, b,
          $urandom_range(0, 499) == 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_set_assoc.md
# btb_set_assoc

Parametrised set-associative branch target buffer, the successor to the direct-mapped BTB in the fetch stage. It is indexed by the word-aligned fetch PC and returns a registered hit, target and way one cycle after a lookup. Resolved branches from execute train it through an update port. It supports per-entry invalidation and a multi-cycle sweep flush, so the storage can map to single-port-per-way RAM.

## Interface
Parameters:
- NUM_SETS, 64, number of sets; power of two, ≥2. IDX_W = log2(NUM_SETS).
- NUM_WAYS, 2, associativity; 1, 2 or 4. WAY_W = max(1, log2(NUM_WAYS)).
- Derived: TAG_W = 30 − IDX_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  lookup request this cycle.
- lookup_pc  in  [31:2]  fetch PC of the request.
- resp_valid  out  1  response valid; one cycle after the accepted lookup.
- resp_hit  out  1  tag match in a valid way.
- resp_target  out  [31:2]  predicted target; 0 when resp_hit=0.
- resp_way  out  WAY_W  way that hit; 0 on a miss.
- upd_valid  in  1  train request.
- upd_pc  in  [31:2]  branch PC.
- upd_target  in  [31:2]  resolved target.
- inv_valid  in  1  invalidate the entry matching inv_pc.
- inv_pc  in  [31:2]  PC to invalidate.
- flush  in  1  start a full-table sweep.
- busy  out  1  sweep in progress.

## Operation
- Address split: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]. Per way: valid, tag, target.
- Per-set replacement state: a round-robin victim pointer, WAY_W bits.
- FSM has two states, SWEEP and READY.
  - rst → SWEEP with set counter 0.
  - In SWEEP, each cycle clears valid for all ways and zeroes the victim pointer of set[counter], then increments the counter.
  - After the counter reaches NUM_SETS−1 → READY.
  - flush in READY → SWEEP with counter 0.
  - flush in SWEEP restarts the counter at 0.
- Lookup in READY: compare the tag against all ways of the set.
  - At most one way can match (invariant maintained by update).
  - Result is registered and appears on resp_* next cycle.
- Lookup in SWEEP: resp_valid=1 next cycle with resp_hit=0, target 0, way 0.
- Update in READY:
  - If the tag matches a valid way, overwrite that way's target in place; pointer unchanged.
  - Else, if any way is invalid, fill the lowest-indexed invalid way; pointer unchanged.
  - Else, fill the way at the pointer, then pointer ← (pointer+1) mod NUM_WAYS.
- Invalidate in READY: clear valid of the matching way, if any. A miss has no effect.
- Update and invalidate are ignored in SWEEP.
- Same-cycle conflicts:
  - Lookup alongside update/invalidate to the same set sees pre-write contents (read-before-write).
  - Update and invalidate with the same upd_pc/inv_pc: invalidate wins; the entry ends invalid and nothing is allocated.
  - Update and invalidate to different PCs: both take effect.
- NUM_WAYS=1 degenerates to direct-mapped: the pointer is unused and resp_way is always 0.

## Timing
- Lookup latency is 1 cycle. Throughput is one lookup per cycle; there is no back-pressure.
- Update and invalidate commit at the clock edge; a lookup in the following cycle observes them.
- Sweep length is exactly NUM_SETS cycles. busy=1 from the cycle after rst/flush is sampled through the last sweep cycle; busy=0 the cycle the FSM is READY.
- During rst all outputs are 0, except busy: busy=1 in the first cycle after rst is sampled high.
- After rst deasserts, busy stays 1 for NUM_SETS cycles.
- resp_valid follows lookup_valid delayed by 1 cycle, and is 0 in the cycle after rst.

## Test plan
- Reset sweep: hold rst 2 cycles, release → busy=1 for exactly 64 cycles, then 0. A lookup during the sweep → resp_valid=1, resp_hit=0.
- Train/hit: upd 0x0000_1000 → 0x0000_2000.
  - Next-cycle lookup 0x0000_1000 → resp_hit=1, target 0x0000_2000 (pc[31:2]=0x400, target[31:2]=0x800), way 0.
  - Lookup 0x0000_1004 → miss.
- Conflict/replacement (64 sets, 2 ways): fill 0x1000, 0x1100 and 0x1200 (same set 0).
  - 0x1000 is evicted (pointer 0 → 1).
  - Lookups: 0x1100 hits way 1, 0x1200 hits way 0, 0x1000 misses.
  - Re-updating 0x1100 with a new target changes the target only; pointer stays 1.
- Invalidate: inv 0x1200 → lookup misses. The next update to set 0 fills way 0, the lowest invalid way.
- Same-cycle hazards:
  - A lookup in the same cycle as the update that creates it → miss; the lookup one cycle later → hit.
  - upd+inv on the same PC → miss afterwards.
- Flush mid-operation: train 4 entries, assert flush, re-assert flush 10 cycles in → busy lasts 10+64 cycles. Updates during the sweep are dropped; afterwards all 4 entries miss.
